// File: rtl/anton_neopixel_sequencer_if.sv
// Control/status bundle between the NeoPixel register block, the sequencer and the encoder.
interface anton_neopixel_sequencer_if #(
    parameter int unsigned BUFFER_END = 255
);
    localparam int unsigned BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;

    logic                   regCtrlRun;
    logic                   regCtrlLoop;
    logic                   regCtrl32bit;
    logic [BUFFER_BITS-1:0] regMax;
    logic                   state;
    logic [BUFFER_BITS-1:0] pixelIndex;
    logic [4:0]             pixelBitIndex;
    logic [2:0]             bitPatternIndex;
    logic                   frameDone;
    logic                   halted;

    modport master (
        output regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
        input  state, pixelIndex, pixelBitIndex, bitPatternIndex, frameDone, halted
    );

    modport slave (
        input  regCtrlRun, regCtrlLoop, regCtrl32bit, regMax,
        output state, pixelIndex, pixelBitIndex, bitPatternIndex, frameDone, halted
    );
endinterface

// File: rtl/anton_neopixel_sequencer.sv
// NeoPixel stream timing sequencer: frame start/end, looping, latch interval and the
// pixel / colour-bit / pattern-slot counters consumed by the combinational encoder.
module anton_neopixel_sequencer #(
    parameter int unsigned BUFFER_END   = 255,
    parameter int unsigned RESET_CYCLES = 400
) (
    input  logic                        clk7mhz,
    input  logic                        rstn,
    anton_neopixel_sequencer_if.slave   bus
);
    localparam int unsigned BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
    localparam int unsigned RC_BITS     = $clog2(RESET_CYCLES);
    localparam logic [RC_BITS-1:0]     RC_LAST = RC_BITS'(RESET_CYCLES - 1);
    localparam logic [BUFFER_BITS-1:0] END8    = BUFFER_BITS'(BUFFER_END);
    localparam logic [BUFFER_BITS-1:0] END32   = BUFFER_BITS'(BUFFER_END >> 2);
    localparam logic ENUM_STATE_RESET    = 1'b0;
    localparam logic ENUM_STATE_TRANSMIT = 1'b1;

    typedef enum logic [1:0] {
        S_RESET_WAIT = 2'd0,
        S_TRANSMIT   = 2'd1,
        S_HALT       = 2'd2
    } fsm_t;

    fsm_t                   r_fsm, w_fsm_nxt;
    logic [RC_BITS-1:0]     r_reset_cnt, w_reset_cnt_nxt;
    logic                   r_mode32, w_mode32_nxt;
    logic [BUFFER_BITS-1:0] r_max, w_max_nxt;
    logic [BUFFER_BITS-1:0] r_pix, w_pix_nxt;
    logic [4:0]             r_bit, w_bit_nxt;
    logic [2:0]             r_pat, w_pat_nxt;
    logic                   w_frame_done_nxt;
    logic [BUFFER_BITS-1:0] w_max_clamped;
    logic [BUFFER_BITS-1:0] w_pix_idx_nxt;
    logic                   w_frame_end;

    logic                   r_state;
    logic [BUFFER_BITS-1:0] r_pix_idx;
    logic                   r_frame_done;
    logic                   r_halted;

    // Pixel limit clamped to the buffer, counted in pixels of the requested width
    always_comb begin
        w_max_clamped = bus.regMax;
        if (bus.regCtrl32bit) begin
            if (bus.regMax > END32) w_max_clamped = END32;
        end else begin
            if (bus.regMax > END8) w_max_clamped = END8;
        end
    end

    assign w_frame_end = (r_pat == 3'd7) && (r_bit == 5'd23) && (r_pix == r_max);

    // Next state and counters; indices fall back to zero outside an active frame
    always_comb begin
        w_fsm_nxt        = r_fsm;
        w_reset_cnt_nxt  = r_reset_cnt;
        w_mode32_nxt     = r_mode32;
        w_max_nxt        = r_max;
        w_pix_nxt        = '0;
        w_bit_nxt        = '0;
        w_pat_nxt        = '0;
        w_frame_done_nxt = 1'b0;
        case (r_fsm)
            S_RESET_WAIT: begin
                if (r_reset_cnt != RC_LAST) begin
                    w_reset_cnt_nxt = r_reset_cnt + RC_BITS'(1);
                end else if (bus.regCtrlRun) begin
                    w_fsm_nxt    = S_TRANSMIT;
                    w_mode32_nxt = bus.regCtrl32bit;
                    w_max_nxt    = w_max_clamped;
                end
            end
            S_TRANSMIT: begin
                if (w_frame_end) begin
                    // A run drop coinciding with the last slot still completes the frame
                    w_frame_done_nxt = 1'b1;
                    w_reset_cnt_nxt  = '0;
                    w_fsm_nxt        = (bus.regCtrlLoop || !bus.regCtrlRun) ? S_RESET_WAIT : S_HALT;
                end else if (!bus.regCtrlRun) begin
                    w_reset_cnt_nxt = '0;
                    w_fsm_nxt       = S_RESET_WAIT;
                end else begin
                    w_pat_nxt = r_pat + 3'd1;
                    w_bit_nxt = r_bit;
                    w_pix_nxt = r_pix;
                    if (r_pat == 3'd7) begin
                        if (r_bit == 5'd23) begin
                            w_bit_nxt = '0;
                            w_pix_nxt = r_pix + BUFFER_BITS'(1);
                        end else begin
                            w_bit_nxt = r_bit + 5'd1;
                        end
                    end
                end
            end
            S_HALT: begin
                if (!bus.regCtrlRun) begin
                    w_reset_cnt_nxt = '0;
                    w_fsm_nxt       = S_RESET_WAIT;
                end
            end
            default: begin
                w_reset_cnt_nxt = '0;
                w_fsm_nxt       = S_RESET_WAIT;
            end
        endcase
    end

    assign w_pix_idx_nxt = w_mode32_nxt ? BUFFER_BITS'({w_pix_nxt, 2'b00}) : w_pix_nxt;

    always_ff @(posedge clk7mhz or negedge rstn) begin
        if (!rstn) begin
            r_fsm        <= S_RESET_WAIT;
            r_reset_cnt  <= '0;
            r_mode32     <= 1'b0;
            r_max        <= '0;
            r_pix        <= '0;
            r_bit        <= '0;
            r_pat        <= '0;
            r_state      <= ENUM_STATE_RESET;
            r_pix_idx    <= '0;
            r_frame_done <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_fsm        <= w_fsm_nxt;
            r_reset_cnt  <= w_reset_cnt_nxt;
            r_mode32     <= w_mode32_nxt;
            r_max        <= w_max_nxt;
            r_pix        <= w_pix_nxt;
            r_bit        <= w_bit_nxt;
            r_pat        <= w_pat_nxt;
            r_state      <= (w_fsm_nxt == S_TRANSMIT) ? ENUM_STATE_TRANSMIT : ENUM_STATE_RESET;
            r_pix_idx    <= w_pix_idx_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_halted     <= (w_fsm_nxt == S_HALT);
        end
    end

    assign bus.state           = r_state;
    assign bus.pixelIndex      = r_pix_idx;
    assign bus.pixelBitIndex   = r_bit;
    assign bus.bitPatternIndex = r_pat;
    assign bus.frameDone       = r_frame_done;
    assign bus.halted          = r_halted;
endmodule
